// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential arithmetic unit.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative mul/div datapath: shift-add multiply and restoring divide.
module seq_alu_iter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               en_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_nxt_o
);

  // Upper half: accumulator (mul) or partial remainder (div).
  // Lower half: multiplier bits (mul) or dividend-in / quotient-out bits (div).
  logic [2*WIDTH-1:0] acc_q, acc_d, iter_d;
  logic [WIDTH:0]     sum, shifted;

  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_i} : '0);
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    if (div_i) begin
      if (shifted >= {1'b0, b_i}) begin
        iter_d = {WIDTH'(shifted - {1'b0, b_i}), acc_q[WIDTH-2:0], 1'b1};
      end else begin
        iter_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_d = {sum, acc_q[WIDTH-1:1]};
    end

    acc_d = acc_q;
    if (load_i) begin
      acc_d = {{WIDTH{1'b0}}, a_i};
    end else if (en_i) begin
      acc_d = iter_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/seq_alu.sv
// Clocked add/sub/mul/div unit with start/busy/done handshake and registered result.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               flag_q, flag_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               load, en;
  logic [WIDTH:0]     add_w, sub_w;
  logic [2*WIDTH-1:0] iter_nxt;

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .en_i      (en),
    .div_i     (op_q == OP_DIV),
    .a_i       (x),
    .b_i       (y_q),
    .acc_nxt_o (iter_nxt)
  );

  always_comb begin
    add_w    = {1'b0, x} + {1'b0, y};
    sub_w    = {1'b0, x} - {1'b0, y};
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    result_d = result_q;
    flag_d   = flag_q;
    load     = 1'b0;
    en       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op_e'(op);
          y_d  = y;
          case (op_e'(op))
            OP_ADD: begin
              result_d = {{WIDTH{1'b0}}, add_w[WIDTH-1:0]};
              flag_d   = add_w[WIDTH];
              state_d  = S_DONE;
            end
            OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, sub_w[WIDTH-1:0]};
              flag_d   = sub_w[WIDTH];
              state_d  = S_DONE;
            end
            OP_MUL: begin
              load    = 1'b1;
              cnt_d   = CNT_W'(WIDTH);
              state_d = S_RUN;
            end
            OP_DIV: begin
              if (y == '0) begin
                result_d = {x, {WIDTH{1'b1}}};
                flag_d   = 1'b1;
                state_d  = S_DONE;
              end else begin
                load    = 1'b1;
                cnt_d   = CNT_W'(WIDTH);
                state_d = S_RUN;
              end
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        en    = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        // Final iteration: capture the datapath's next value on the same edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = iter_nxt;
          flag_d   = (op_q == OP_MUL) && (|iter_nxt[2*WIDTH-1:WIDTH]);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      y_q      <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag   = flag_q;

endmodule
